cpu_loader: RTL and testbench

Serial-driven program loader and CPU controller. It sits between the UART receiver/transmitter and the CPU/memory pair. It interprets a byte-oriented command stream to write and read back memory, sets the CPU start address, and controls CPU reset and halt. While the loader owns memory (CPU held in reset or halted), the top level muxes the memory ports to the loader using `owner`.

---
 rtl/cpu_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_cpu_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_loader.sv
// cpu_loader: serial command interpreter between the UART and the CPU/memory pair.
// It writes memory, reads it back, sets the CPU start address, and drives CPU
// reset and halt from a byte stream.
//
// Commands (first byte), arguments, reply:
//   'W' addr_hi addr_lo count data...  write bytes, reply 'K' ('!' when not owner)
//   'R' addr_hi addr_lo count          send count bytes read back ('!' when not owner)
//   'X' addr_hi addr_lo                load start address, pulse cpu_reset, release, reply 'K'
//   'H'                                halt the CPU, wait for cpu_halted, take memory, reply 'K'
//   'S'                                reply {6'b0, overrun, cpu_halted}, then clear overrun
//   other                              reply '?'
//   A count of 0 means 256. Addresses wrap modulo 2^addr_width.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rx_data, rx_valid          received byte and its one-cycle strobe
//   tx_data, tx_start, tx_busy byte to send, one-cycle send strobe, transmitter busy
//   mem_waddr, mem_data_in,
//   mem_write                  memory write port (one-cycle strobe)
//   mem_raddr, mem_data_out    memory read port (data two cycles after the address)
//   owner                      1 while the loader drives the memory ports
//   cpu_reset, cpu_halt,
//   cpu_start_address,
//   cpu_halted                 CPU control and status
//
// Build option: define LOADER_READBACK_EN to implement 'R'. Without it 'R' is
// an unknown command and mem_raddr is tied to 0.

module cpu_loader #(
  parameter int unsigned addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  output logic [addr_width-1:0] mem_raddr,
  input  logic [7:0]            mem_data_out,
  output logic                  owner,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  output logic [addr_width-1:0] cpu_start_address,
  input  logic                  cpu_halted
);

  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_X    = 8'h58;
  localparam logic [7:0] CMD_H    = 8'h48;
  localparam logic [7:0] CMD_S    = 8'h53;
`ifdef LOADER_READBACK_EN
  localparam logic [7:0] CMD_R    = 8'h52;
`endif
  localparam logic [7:0] RPL_OK   = 8'h4B;
  localparam logic [7:0] RPL_DENY = 8'h21;
  localparam logic [7:0] RPL_UNK  = 8'h3F;

  typedef enum logic [3:0] {
    IDLE,
    AHI,
    ALO,
    CNT,
    WDATA,
`ifdef LOADER_READBACK_EN
    RREQ,
    RW1,
    RW2,
`endif
    XRST,
    HWAIT,
    TXWAIT,
    TXGUARD
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [8:0]            count_q, count_d;
  logic                  denied_q, denied_d;
  logic                  xcnt_q, xcnt_d;
  logic [addr_width-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  mem_write_q, mem_write_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  owner_q, owner_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_halt_q, cpu_halt_d;
  logic [addr_width-1:0] start_q, start_d;
  logic                  overrun_q, overrun_d;
  logic                  tx_fire;
  logic                  decode_en;
  logic                  waiting_input;
`ifdef LOADER_READBACK_EN
  logic [addr_width-1:0] raddr_q, raddr_d;
  logic                  rd_active_q, rd_active_d;
`else
  logic                  unused_rdata;
  assign unused_rdata = ^mem_data_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      denied_q    <= 1'b0;
      xcnt_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      tx_data_q   <= '0;
      owner_q     <= 1'b1;
      cpu_reset_q <= 1'b1;
      cpu_halt_q  <= 1'b0;
      start_q     <= '0;
      overrun_q   <= 1'b0;
`ifdef LOADER_READBACK_EN
      raddr_q     <= '0;
      rd_active_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      denied_q    <= denied_d;
      xcnt_q      <= xcnt_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
      tx_data_q   <= tx_data_d;
      owner_q     <= owner_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_halt_q  <= cpu_halt_d;
      start_q     <= start_d;
      overrun_q   <= overrun_d;
`ifdef LOADER_READBACK_EN
      raddr_q     <= raddr_d;
      rd_active_q <= rd_active_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_hi_d     = addr_hi_q;
    addr_d        = addr_q;
    count_d       = count_q;
    denied_d      = denied_q;
    xcnt_d        = xcnt_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    mem_write_d   = 1'b0;
    tx_data_d     = tx_data_q;
    owner_d       = owner_q;
    cpu_reset_d   = cpu_reset_q;
    cpu_halt_d    = cpu_halt_q;
    start_d       = start_q;
    overrun_d     = overrun_q;
    tx_fire       = 1'b0;
    decode_en     = 1'b0;
    waiting_input = 1'b0;
`ifdef LOADER_READBACK_EN
    raddr_d       = raddr_q;
    rd_active_d   = rd_active_q;
`endif

    case (state_q)
      IDLE: begin
        decode_en = 1'b1;
      end
      AHI: begin
        waiting_input = 1'b1;
        if (rx_valid) begin
          addr_hi_d = rx_data;
          state_d   = ALO;
        end
      end
      ALO: begin
        waiting_input = 1'b1;
        if (rx_valid) begin
          addr_d = addr_width'({addr_hi_q, rx_data});
          if (cmd_q == CMD_X) begin
            start_d     = addr_width'({addr_hi_q, rx_data});
            cpu_reset_d = 1'b1;
            cpu_halt_d  = 1'b0;
            xcnt_d      = 1'b0;
            state_d     = XRST;
          end else begin
            state_d = CNT;
          end
        end
      end
      CNT: begin
        waiting_input = 1'b1;
        if (rx_valid) begin
          count_d  = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          denied_d = ~owner_q;
`ifdef LOADER_READBACK_EN
          if (cmd_q == CMD_R) begin
            if (owner_q) begin
              rd_active_d = 1'b1;
              state_d     = RREQ;
            end else begin
              tx_data_d = RPL_DENY;
              state_d   = TXWAIT;
            end
          end else begin
            state_d = WDATA;
          end
`else
          state_d = WDATA;
`endif
        end
      end
      WDATA: begin
        waiting_input = 1'b1;
        if (rx_valid) begin
          // Denied writes still consume data bytes so the stream stays framed.
          if (!denied_q) begin
            waddr_d     = addr_q;
            wdata_d     = rx_data;
            mem_write_d = 1'b1;
          end
          addr_d  = addr_q + addr_width'(1);
          count_d = count_q - 9'd1;
          if (count_q == 9'd1) begin
            tx_data_d = denied_q ? RPL_DENY : RPL_OK;
            state_d   = TXWAIT;
          end
        end
      end
`ifdef LOADER_READBACK_EN
      RREQ: begin
        raddr_d = addr_q;
        state_d = RW1;
      end
      RW1: begin
        state_d = RW2;
      end
      RW2: begin
        tx_data_d = mem_data_out;
        addr_d    = addr_q + addr_width'(1);
        count_d   = count_q - 9'd1;
        state_d   = TXWAIT;
      end
`endif
      XRST: begin
        if (xcnt_q) begin
          cpu_reset_d = 1'b0;
          owner_d     = 1'b0;
          tx_data_d   = RPL_OK;
          state_d     = TXWAIT;
        end else begin
          xcnt_d = 1'b1;
        end
      end
      HWAIT: begin
        if (cpu_halted) begin
          owner_d   = 1'b1;
          tx_data_d = RPL_OK;
          state_d   = TXWAIT;
        end
      end
      TXWAIT: begin
        if (!tx_busy) begin
          tx_fire = 1'b1;
          state_d = TXGUARD;
        end
      end
      TXGUARD: begin
`ifdef LOADER_READBACK_EN
        if (rd_active_q && (count_q != 9'd0)) begin
          state_d = RREQ;
        end else begin
          rd_active_d = 1'b0;
          state_d     = IDLE;
          decode_en   = 1'b1;
        end
`else
        state_d   = IDLE;
        decode_en = 1'b1;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A byte arriving on the cycle we return to IDLE is decoded, not dropped,
    // so command decode also runs from TXGUARD when it heads for IDLE.
    if (decode_en) begin
      waiting_input = 1'b1;
      if (rx_valid) begin
        case (rx_data)
`ifdef LOADER_READBACK_EN
          CMD_W, CMD_X, CMD_R: begin
`else
          CMD_W, CMD_X: begin
`endif
            cmd_d   = rx_data;
            state_d = AHI;
          end
          CMD_H: begin
            cpu_halt_d = 1'b1;
            state_d    = HWAIT;
          end
          CMD_S: begin
            tx_data_d = {6'b0, overrun_q, cpu_halted};
            overrun_d = 1'b0;
            state_d   = TXWAIT;
          end
          default: begin
            tx_data_d = RPL_UNK;
            state_d   = TXWAIT;
          end
        endcase
      end
    end

    if (rx_valid && !waiting_input) begin
      overrun_d = 1'b1;
    end
  end

  // tx_start is taken straight from the TXWAIT condition so it can never
  // coincide with tx_busy; a synchronous reset suppresses it at once.
  assign tx_start          = tx_fire & ~reset;
  assign tx_data           = tx_data_q;
  assign mem_waddr         = waddr_q;
  assign mem_data_in       = wdata_q;
  assign mem_write         = mem_write_q;
  assign owner             = owner_q;
  assign cpu_reset         = cpu_reset_q;
  assign cpu_halt          = cpu_halt_q;
  assign cpu_start_address = start_q;
`ifdef LOADER_READBACK_EN
  assign mem_raddr         = raddr_q;
`else
  assign mem_raddr         = '0;
`endif

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench for cpu_loader: the stimulus pushes expected memory writes
// and reply bytes; a monitor pops and compares them as the DUT produces them.

module tb_cpu_loader;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_data_in;
  logic          mem_write;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_data_out;
  logic          owner;
  logic          cpu_reset;
  logic          cpu_halt;
  logic [AW-1:0] cpu_start_address;
  logic          cpu_halted;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned busy_len = 3;
  logic [7:0]     exp_tx[$];
  logic [AW+7:0]  exp_wr[$];
  logic [7:0]     mem [0:(1<<AW)-1];

  cpu_loader #(.addr_width(AW)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .mem_waddr(mem_waddr), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_raddr(mem_raddr), .mem_data_out(mem_data_out),
    .owner(owner), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
    .cpu_start_address(cpu_start_address), .cpu_halted(cpu_halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_tx.size() + exp_wr.size(), 0);
    exp_tx.delete();
    exp_wr.delete();
    repeat (3) @(posedge clk);
  endtask

  // Memory model: write on mem_write, read data follows mem_raddr.
  initial begin
    mem_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_write === 1'b1) mem[mem_waddr] = mem_data_in;
      mem_data_out = mem[mem_raddr];
    end
  end

  // Transmitter model: busy rises the cycle after tx_start for busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic          prev_tx;
    logic [AW+7:0] ew;
    logic [7:0]    et;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_write === 1'b1) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", mem_write, 0);
        end else begin
          ew = exp_wr.pop_front();
          check("wr_addr", mem_waddr, ew[AW+7:8]);
          check("wr_data", mem_data_in, ew[7:0]);
        end
      end
      if (tx_start === 1'b1) begin
        check("tx_while_busy", tx_busy, 0);
        check("tx_back_to_back", prev_tx, 0);
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", tx_start, 0);
        end else begin
          et = exp_tx.pop_front();
          check("tx_data", tx_data, et);
        end
      end
      prev_tx = (tx_start === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_data = '0;
    rx_valid = 1'b0;
    cpu_halted = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_owner", owner, 1);
    check("rst_cpu_halt", cpu_halt, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_start_addr", cpu_start_address, 0);
    check("rst_tx_data", tx_data, 0);

    // Basic write of three bytes.
    exp_wr.push_back({9'h010, 8'hAA});
    exp_wr.push_back({9'h011, 8'hBB});
    exp_wr.push_back({9'h012, 8'hCC});
    exp_tx.push_back(8'h4B);
    send(8'h57); send(8'h00); send(8'h10); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    drain(300);

    // Address wrap at 2^9.
    exp_wr.push_back({9'h1FF, 8'h11});
    exp_wr.push_back({9'h000, 8'h22});
    exp_tx.push_back(8'h4B);
    send(8'h57); send(8'h01); send(8'hFF); send(8'h02);
    send(8'h11); send(8'h22);
    drain(300);

`ifdef LOADER_READBACK_EN
    // Readback with a slow transmitter.
    busy_len = 50;
    exp_tx.push_back(8'hAA);
    exp_tx.push_back(8'hBB);
    exp_tx.push_back(8'hCC);
    send(8'h52); send(8'h00); send(8'h10); send(8'h03);
    drain(1000);
    busy_len = 3;
`else
    exp_tx.push_back(8'h3F);
    send(8'h52);
    drain(300);
`endif

    // Start the CPU at 0x020.
    exp_tx.push_back(8'h4B);
    send(8'h58); send(8'h00); send(8'h20);
    @(negedge clk);
    check("x_reset_c1", cpu_reset, 1);
    check("x_start_addr", cpu_start_address, 9'h020);
    check("x_halt_low", cpu_halt, 0);
    @(negedge clk);
    check("x_reset_c2", cpu_reset, 1);
    check("x_owner_c2", owner, 1);
    @(negedge clk);
    check("x_reset_c3", cpu_reset, 0);
    check("x_owner_c3", owner, 0);
    drain(300);

    // Write while the CPU owns memory is consumed and refused.
    exp_tx.push_back(8'h21);
    send(8'h57); send(8'h00); send(8'h00); send(8'h01); send(8'h55);
    drain(300);
    check("deny_owner", owner, 0);

    // Halt, with a stray byte during the wait.
    exp_tx.push_back(8'h4B);
    send(8'h48);
    @(negedge clk);
    check("h_halt_req", cpu_halt, 1);
    check("h_owner_wait", owner, 0);
    send(8'h77);
    repeat (6) @(posedge clk);
    #1 cpu_halted = 1'b1;
    drain(300);
    check("h_owner_after", owner, 1);
    check("h_halt_hold", cpu_halt, 1);
    exp_tx.push_back(8'h03);
    send(8'h53);
    drain(300);
    exp_tx.push_back(8'h01);
    send(8'h53);
    drain(300);

    // Halt when already halted.
    exp_tx.push_back(8'h4B);
    send(8'h48);
    drain(300);

    // Reset in the middle of a write.
    exp_wr.push_back({9'h030, 8'hD1});
    exp_wr.push_back({9'h031, 8'hD2});
    send(8'h57); send(8'h00); send(8'h30); send(8'h04);
    send(8'hD1); send(8'hD2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_owner", owner, 1);
    check("mid_cpu_halt", cpu_halt, 0);
    check("mid_mem_write", mem_write, 0);
    exp_tx.push_back(8'h01);
    send(8'h53);
    drain(300);
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
